// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: fills a single-port block RAM with a pattern, reads it back through a
// latency-matched pipeline and reports pass/fail, error count and first failing address.
module ram_bist_ctrl #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  start,
    input  logic [1:0]            pattern_sel,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    input  logic [DATA_WIDTH-1:0] douta,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);
    localparam int L = READ_LATENCY;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            sel;
    logic                  go, behind;
    logic                  pv [0:L];
    logic [ADDR_WIDTH-1:0] pa [0:L];
    logic [DATA_WIDTH-1:0] pe [0:L];

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] s, input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] na;
        na = ~a;
        return s == 2'd0 ? DATA_WIDTH'(a) :
               s == 2'd1 ? DATA_WIDTH'(na) :
               s == 2'd2 ? (a[0] ? DATA_WIDTH'(8'hAA) : DATA_WIDTH'(8'h55)) : '0;
    endfunction

    assign go = (state == IDLE || state == DONE) && start;

    // Stage 0 holds the request currently on addra; stage L lines up with douta.
    // DRAIN ends once only the compare stage may still hold a valid entry.
    always_comb begin
        behind = 1'b0;
        for (int i = 0; i < L; i++) behind = behind | pv[i];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = go ? WRITE : state;
            WRITE:      state_nxt = &addr ? READ : WRITE;
            READ:       state_nxt = &addr ? DRAIN : READ;
            DRAIN:      state_nxt = behind ? DRAIN : DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            addr           <= '0;
            sel            <= '0;
            ena            <= 1'b0;
            wea            <= 1'b0;
            addra          <= '0;
            dina           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            for (int i = 0; i <= L; i++) pv[i] <= 1'b0;
        end else begin
            addr  <= go ? '0 : (state == WRITE || state == READ) ? addr + ADDR_WIDTH'(1) : addr;
            sel   <= go ? pattern_sel : sel;
            ena   <= state == WRITE || state == READ;
            wea   <= state == WRITE;
            addra <= addr;
            dina  <= state == WRITE ? pattern(sel, addr) : '0;
            busy  <= state == WRITE || state == READ || state == DRAIN;
            done  <= state == DONE && state_nxt == DONE;
            pass  <= state == DONE && state_nxt == DONE && err_count == '0;
            pv[0] <= state == READ;
            pa[0] <= addr;
            pe[0] <= pattern(sel, addr);
            for (int i = 1; i <= L; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pe[i] <= pe[i-1];
            end
            if (go) begin
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (pv[L] && douta != pe[L]) begin
                err_count      <= err_count + (ADDR_WIDTH+1)'(err_count != DEPTH);
                first_err_addr <= err_count == '0 ? pa[L] : first_err_addr;
            end
        end
    end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: two controllers (read latency 1 and 2) against behavioural RAMs with
// injectable faults; expected results are queued at start and compared when done rises.
module tb_ram_bist_ctrl;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rs [2];
    logic       st [2];
    logic [1:0] sl [2];
    logic       en [2];
    logic       we [2];
    logic [7:0] ad [2];
    logic [7:0] di [2];
    logic [7:0] dq [2];
    logic       bz [2];
    logic       dn [2];
    logic       ps [2];
    logic [8:0] ec [2];
    logic [7:0] fe [2];
    int         md [2];

    ram_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1)) dut0 (
        .clka(clk), .rsta(rs[0]), .start(st[0]), .pattern_sel(sl[0]), .ena(en[0]), .wea(we[0]),
        .addra(ad[0]), .dina(di[0]), .douta(dq[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
        .err_count(ec[0]), .first_err_addr(fe[0]));

    ram_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(2)) dut1 (
        .clka(clk), .rsta(rs[1]), .start(st[1]), .pattern_sel(sl[1]), .ena(en[1]), .wea(we[1]),
        .addra(ad[1]), .dina(di[1]), .douta(dq[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
        .err_count(ec[1]), .first_err_addr(fe[1]));

    function automatic logic [7:0] pat(input int s, input logic [7:0] a);
        case (s)
            0:       return a;
            1:       return ~a;
            2:       return a[0] ? 8'hAA : 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    // mode 0: healthy, 1: bit 3 stuck-at-1 at 0x10, 2: every read returns 0
    function automatic logic [7:0] rd_fault(input int m, input logic [7:0] a, input logic [7:0] v);
        if (m == 2) return 8'h00;
        if (m == 1 && a == 8'h10) return v | 8'h08;
        return v;
    endfunction

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] rd0 = 8'hEE, rd1a = 8'hEE, rd1b = 8'hEE;
    assign dq[0] = rd0;
    assign dq[1] = rd1b;

    always @(posedge clk) begin
        if (en[0] && we[0]) mem0[ad[0]] <= di[0];
        if (en[0] && !we[0]) rd0 <= rd_fault(md[0], ad[0], mem0[ad[0]]);
    end

    always @(posedge clk) begin
        if (en[1] && we[1]) mem1[ad[1]] <= di[1];
        if (en[1] && !we[1]) rd1a <= rd_fault(md[1], ad[1], mem1[ad[1]]);
        rd1b <= rd1a;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {int cyc; int err; int first; bit pass;} exp_t;
    exp_t q [$];

    task automatic push_exp(input int d, input int s, input int m);
        exp_t e;
        logic [7:0] w;
        e.err = 0;
        e.first = 0;
        for (int a = 0; a < 256; a++) begin
            w = pat(s, 8'(a));
            if (rd_fault(m, 8'(a), w) != w) begin
                if (e.err == 0) e.first = a;
                e.err++;
            end
        end
        e.cyc = 2 * 256 + (d == 0 ? 1 : 2) + 2;
        e.pass = e.err == 0;
        q.push_back(e);
    endtask

    task automatic pulse_start(input int d, input int s, input int m);
        md[d] = m;
        sl[d] = s[1:0];
        @(negedge clk);
        st[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic run(input int d, input int s, input int m, input bit glitch);
        exp_t e;
        int   n = 0;
        bit   g = 1'b0;
        bit   seen = 1'b0;
        push_exp(d, s, m);
        pulse_start(d, s, m);
        while (!seen && n < 3000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            st[d] = glitch && !g && we[d] && ad[d] == 8'h40;
            if (st[d]) g = 1'b1;
            if (we[d]) chk("wdata", di[d], pat(s, ad[d]));
            if (n == 1) begin
                chk("clr_done", dn[d], 0);
                chk("clr_pass", ps[d], 0);
                chk("clr_err", ec[d], 0);
            end
            seen = dn[d];
        end
        st[d] = 1'b0;
        e = q.pop_front();
        if (!seen) chk("timeout", n, e.cyc);
        else begin
            chk("cycles", n, e.cyc);
            chk("pass", ps[d], e.pass);
            chk("err_count", ec[d], e.err);
            chk("first_err", fe[d], e.first);
            chk("busy_done", bz[d], 0);
            chk("ena_done", en[d], 0);
        end
        if (glitch) chk("glitch_sent", g, 1);
    endtask

    task automatic abort_run();
        int n = 0;
        bit hit = 1'b0;
        pulse_start(0, 0, 0);
        while (!hit && n < 2000) begin
            @(negedge clk);
            n++;
            hit = en[0] && !we[0] && ad[0] == 8'h80;
        end
        chk("abort_reach", hit, 1);
        rs[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rs[0] = 1'b0;
        chk("abort_ena", en[0], 0);
        chk("abort_wea", we[0], 0);
        chk("abort_busy", bz[0], 0);
        chk("abort_done", dn[0], 0);
        chk("abort_err", ec[0], 0);
        chk("abort_first", fe[0], 0);
        repeat (5) @(negedge clk);
        chk("abort_idle", {en[0], bz[0], dn[0]}, 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rs[d] = 1'b1;
            st[d] = 1'b0;
            sl[d] = 2'd0;
            md[d] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ena", en[d], 0);
            chk("rst_wea", we[d], 0);
            chk("rst_addra", ad[d], 0);
            chk("rst_dina", di[d], 0);
            chk("rst_busy", bz[d], 0);
            chk("rst_done", dn[d], 0);
            chk("rst_pass", ps[d], 0);
            chk("rst_err", ec[d], 0);
            chk("rst_first", fe[d], 0);
            rs[d] = 1'b0;
        end
        run(0, 0, 0, 1'b0);
        run(0, 2, 1, 1'b0);
        run(0, 2, 2, 1'b0);
        run(0, 1, 2, 1'b0);
        run(1, 3, 0, 1'b0);
        run(0, 0, 0, 1'b1);
        abort_run();
        run(0, 2, 1, 1'b0);
        run(0, 0, 0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
